pipelined_adder_tree: RTL and testbench
=======================================

Name: pipelined_adder_tree

Overview:
- Parametrised, pipelined, unsigned multi-operand adder. Sums NUM_INPUTS operands of IN_WIDTH bits each into one full-precision result.
- Generalises the fixed two-operand ripple adder. Adds registered tree levels, valid/ready flow control and a synchronous flush.
- Used as the neighbour-count engine ahead of the cell-rule logic: with NUM_INPUTS=8 and IN_WIDTH=1 it produces the live-neighbour count 0..8.

Parameters:
- NUM_INPUTS, 8, number of operands; legal range 2..64.
- IN_WIDTH, 1, width of each unsigned operand; legal range 1..16.
- LEVELS, $clog2(NUM_INPUTS), derived localparam; tree depth and pipeline latency in cycles.
- OUT_WIDTH, IN_WIDTH+LEVELS, derived localparam; result width, which never overflows.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous flush of all in-flight data.
- in_data  input  NUM_INPUTS*IN_WIDTH  packed operands; operand i is in_data[i*IN_WIDTH +: IN_WIDTH].
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts in_data this cycle.
- out_sum  output  OUT_WIDTH  sum of all operands of one accepted beat.
- out_valid  output  1  out_sum is valid.
- out_ready  input  1  downstream accepts out_sum.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits cleared, all stage data registers cleared to 0. Gives out_valid=0 and out_sum=0. in_ready=1 immediately after reset.
- Tree structure:
  - Operands are zero-padded to 2**LEVELS entries.
  - Level k adds adjacent pairs, each zero-extended to IN_WIDTH+k+1 bits, and registers the results. There are LEVELS register stages.
  - No truncation anywhere; the final stage width is OUT_WIDTH.
- Latency: a beat accepted at edge N appears on out_sum/out_valid after edge N+LEVELS-1, i.e. LEVELS cycles, with no stalls.
- Transfers: an input beat transfers when in_valid && in_ready. An output beat transfers when out_valid && out_ready.
- Flow control uses a global stall: advance = !out_valid || out_ready; in_ready = advance (combinational).
  - When advance=1, every stage loads from the stage before it. Stage 0 loads the in_data pairwise sums and captures in_valid as its valid bit.
  - When advance=0, every stage holds, and out_sum/out_valid are stable.
- Bubbles are not collapsed. A throughput of 1 beat/cycle is required while out_ready=1.
- Valid discipline: a stage's data register loads only when its incoming valid is 1. When the incoming valid is 0 and advance=1, only the valid bit clears, which keeps the data path quiet.
- out_sum is don't-care while out_valid=0; the bench checks it only when valid.
- clear (synchronous, priority over advance): at the edge, all valid bits go to 0 and data registers hold. in_ready stays = advance. A beat presented in the same cycle as clear is dropped.
- Simultaneous in-transfer and out-transfer in one cycle is the normal case and is fully supported.
- Reset asserted mid-operation drops all in-flight beats with no partial output.
- Elaboration: an out-of-range NUM_INPUTS or IN_WIDTH triggers $error.

Decomposition:
- Shared package (e.g. conway_pkg):
  - NEIGHBOUR_COUNT=8.
  - COUNT_WIDTH=4.
  - Function sum_width(n, w) returning w+$clog2(n), used by instantiators to size the out_sum net.
- One natural sub-module: adder_tree_level, parametrised by pair count and input width. It holds one level of pairwise adds plus its data and valid registers, with advance and clear inputs.
- The top instantiates LEVELS copies of adder_tree_level in a generate loop.

Test Plan:
- Defaults, in_data=8'hFF, one beat, out_ready=1 -> out_valid exactly 3 cycles later with out_sum=4'd8. Then in_data=8'h00 -> 4'd0. Then 8'hA5 -> 4'd4.
- Streaming: 100 random back-to-back beats, out_ready=1 -> in_ready constant 1, 100 outputs in order, each equal to the popcount of its input, no gaps.
- Backpressure: random out_ready at 50% duty -> no beat lost or duplicated; out_sum stable while out_valid && !out_ready; in_ready==(!out_valid||out_ready) every cycle.
- NUM_INPUTS=9, IN_WIDTH=3, all operands 3'd7 -> LEVELS=4, OUT_WIDTH=7, out_sum=7'd63 after 4 cycles. With NUM_INPUTS=2, IN_WIDTH=2, operands 3 and 3 -> 3'd6 after 1 cycle.
- Flush: load 3 beats, assert clear for 1 cycle with in_valid=1 -> no output for any of the 4 beats; the next beat after clear is output correctly.
- Reset mid-flight: pulse rst_n low asynchronously (not on a clock edge) with 2 beats in flight and out_ready=0 -> out_valid falls immediately, in_ready=1 after release, no stale beat emitted.

Source files
------------

// File: rtl/pipelined_adder_tree_pkg.sv
// Shared constants and sizing helper for the neighbour-count adder tree.
// Instantiators use sum_width() to size the net that receives out_sum.
package pipelined_adder_tree_pkg;

    localparam int NEIGHBOUR_COUNT = 8;
    localparam int COUNT_WIDTH     = 4;

    function automatic int sum_width(input int n, input int w);
        return w + $clog2(n);
    endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered level of the adder tree: PAIRS pairwise adds, widened by one bit,
// with a shared valid bit. The data registers load only when the incoming beat is valid.
module adder_tree_level
    import pipelined_adder_tree_pkg::*;
#(
    parameter int PAIRS = 1,
    parameter int IN_W  = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      advance_i,
    input  logic                      clear_i,
    input  logic [2*PAIRS*IN_W-1:0]   data_i,
    input  logic                      valid_i,
    output logic [PAIRS*(IN_W+1)-1:0] data_o,
    output logic                      valid_o
);

    localparam int OW = IN_W + 1;

    logic [PAIRS*OW-1:0] sum_d;
    logic [PAIRS*OW-1:0] data_q;
    logic                valid_q;

    always_comb begin
        sum_d = '0;
        for (int p = 0; p < PAIRS; p++) begin
            sum_d[p*OW +: OW] = OW'(data_i[2*p*IN_W +: IN_W]) + OW'(data_i[(2*p+1)*IN_W +: IN_W]);
        end
    end

    // clear wins over advance; data is held so a flush does not toggle the data path.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (advance_i) begin
            valid_q <= valid_i;
            if (valid_i) begin
                data_q <= sum_d;
            end
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/pipelined_adder_tree.sv
// Pipelined unsigned multi-operand adder: LEVELS registered pairwise-add levels under a
// single global stall (advance), with a synchronous flush. Latency is LEVELS cycles.
module pipelined_adder_tree
    import pipelined_adder_tree_pkg::*;
#(
    parameter  int NUM_INPUTS = NEIGHBOUR_COUNT,
    parameter  int IN_WIDTH   = 1,
    localparam int LEVELS     = $clog2(NUM_INPUTS),
    localparam int OUT_WIDTH  = sum_width(NUM_INPUTS, IN_WIDTH)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic [NUM_INPUTS*IN_WIDTH-1:0] in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [OUT_WIDTH-1:0]           out_sum,
    output logic                           out_valid,
    input  logic                           out_ready
);

    localparam int PAD_W = (2**LEVELS) * IN_WIDTH;

    if (NUM_INPUTS < 2 || NUM_INPUTS > 64 || IN_WIDTH < 1 || IN_WIDTH > 16) begin : g_param_err
        $error("pipelined_adder_tree: NUM_INPUTS must be 2..64 and IN_WIDTH 1..16");
    end

    // Every level boundary lives in one flat bus; segment k holds the inputs of level k
    // (2**(LEVELS-k) entries of IN_WIDTH+k bits), and the last segment is out_sum.
    function automatic int seg_off(input int k);
        int o;
        o = 0;
        for (int j = 0; j < k; j++) begin
            o += (2**(LEVELS-j)) * (IN_WIDTH + j);
        end
        return o;
    endfunction

    localparam int BUS_W = seg_off(LEVELS + 1);

    logic [BUS_W-1:0] bus;
    logic [LEVELS:0]  vld;
    logic             advance;

    assign advance = !out_valid || out_ready;
    assign in_ready = advance;

    assign bus[0 +: PAD_W] = PAD_W'(in_data);
    assign vld[0]          = in_valid;

    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        localparam int PAIRS = 2**(LEVELS-k-1);
        localparam int LW    = IN_WIDTH + k;

        adder_tree_level #(
            .PAIRS (PAIRS),
            .IN_W  (LW)
        ) u_level (
            .clk_i     (clk),
            .rst_ni    (rst_n),
            .advance_i (advance),
            .clear_i   (clear),
            .data_i    (bus[seg_off(k) +: 2*PAIRS*LW]),
            .valid_i   (vld[k]),
            .data_o    (bus[seg_off(k+1) +: PAIRS*(LW+1)]),
            .valid_o   (vld[k+1])
        );
    end

    assign out_sum   = bus[seg_off(LEVELS) +: OUT_WIDTH];
    assign out_valid = vld[LEVELS];

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Directed bench for pipelined_adder_tree: default 8x1 neighbour counter plus 9x3 and 2x2 variants.
module tb_pipelined_adder_tree;

    logic clk;
    logic rst_n;

    // default configuration: 8 operands x 1 bit
    logic        a_clear, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0]  a_in_data;
    logic [3:0]  a_out_sum;
    // 9 operands x 3 bits
    logic        w_clear, w_in_valid, w_in_ready, w_out_valid, w_out_ready;
    logic [26:0] w_in_data;
    logic [6:0]  w_out_sum;
    // 2 operands x 2 bits
    logic        t_clear, t_in_valid, t_in_ready, t_out_valid, t_out_ready;
    logic [3:0]  t_in_data;
    logic [2:0]  t_out_sum;

    int errors = 0;
    int checks = 0;
    logic [3:0] exp_q[$];

    pipelined_adder_tree u_dut_a (
        .clk(clk), .rst_n(rst_n), .clear(a_clear), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .out_sum(a_out_sum), .out_valid(a_out_valid), .out_ready(a_out_ready)
    );

    pipelined_adder_tree #(.NUM_INPUTS(9), .IN_WIDTH(3)) u_dut_w (
        .clk(clk), .rst_n(rst_n), .clear(w_clear), .in_data(w_in_data), .in_valid(w_in_valid),
        .in_ready(w_in_ready), .out_sum(w_out_sum), .out_valid(w_out_valid), .out_ready(w_out_ready)
    );

    pipelined_adder_tree #(.NUM_INPUTS(2), .IN_WIDTH(2)) u_dut_t (
        .clk(clk), .rst_n(rst_n), .clear(t_clear), .in_data(t_in_data), .in_valid(t_in_valid),
        .in_ready(t_in_ready), .out_sum(t_out_sum), .out_valid(t_out_valid), .out_ready(t_out_ready)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst_n = 1'b0;
        a_clear = 0; a_in_valid = 0; a_in_data = '0; a_out_ready = 1;
        w_clear = 0; w_in_valid = 0; w_in_data = '0; w_out_ready = 1;
        t_clear = 0; t_in_valid = 0; t_in_data = '0; t_out_ready = 1;
        #3;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
        checks++; if (a_out_sum !== 4'd0) begin errors++; $display("FAIL reset_out_sum: got %0d want 0", a_out_sum); end
        checks++; if (w_out_valid !== 1'b0 || t_out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_variant_valid: got w=%b t=%b want 0", w_out_valid, t_out_valid);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
    endtask

    // one beat on the default DUT with out_ready=1: valid exactly 3 cycles after acceptance
    task automatic send_default(input logic [7:0] d, input logic [3:0] exp, input string name);
        a_out_ready = 1;
        @(negedge clk);
        a_in_valid = 1; a_in_data = d;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            a_in_valid = 0;
            #1;
            if (i < 3) begin
                checks++;
                if (a_out_valid !== 1'b0) begin errors++; $display("FAIL %s_early: cycle %0d out_valid=%b want 0", name, i, a_out_valid); end
            end else begin
                checks++;
                if (a_out_valid !== 1'b1 || a_out_sum !== exp) begin
                    errors++; $display("FAIL %s: out_valid=%b out_sum=%0d want valid=1 sum=%0d", name, a_out_valid, a_out_sum, exp);
                end
            end
        end
        @(negedge clk);
        #1;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL %s_drain: out_valid=%b want 0", name, a_out_valid); end
    endtask

    task automatic test_basic();
        send_default(8'hFF, 4'd8, "basic_ff");
        send_default(8'h00, 4'd0, "basic_00");
        send_default(8'hA5, 4'd4, "basic_a5");
    endtask

    task automatic test_back_to_back();
        int sent = 0; int got = 0; int cyc = 0; logic started = 0;
        exp_q.delete();
        a_out_ready = 1;
        while (got < 100 && cyc < 400) begin
            @(negedge clk);
            if (sent < 100) begin a_in_valid = 1; a_in_data = 8'($urandom_range(0, 255)); end
            else a_in_valid = 0;
            #1;
            checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready: got %b want 1", a_in_ready); end
            if (a_out_valid) begin
                started = 1;
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL stream_extra: out_sum=%0d with nothing expected", a_out_sum); end
                else begin
                    logic [3:0] e;
                    e = exp_q.pop_front();
                    if (a_out_sum !== e) begin errors++; $display("FAIL stream_data: beat %0d got %0d want %0d", got, a_out_sum, e); end
                end
                got++;
            end else if (started) begin
                checks++; errors++; $display("FAIL stream_gap: out_valid=0 after %0d outputs want 1", got);
            end
            if (a_in_valid && a_in_ready) begin
                exp_q.push_back(4'($countones(a_in_data)));
                sent++;
            end
            cyc++;
        end
        a_in_valid = 0;
        checks++; if (got != 100) begin errors++; $display("FAIL stream_count: got %0d outputs want 100", got); end
    endtask

    task automatic test_backpressure();
        int sent = 0; int got = 0; int cyc = 0;
        logic prev_stall = 0; logic [3:0] prev_sum = '0;
        exp_q.delete();
        while ((sent < 60 || exp_q.size() != 0) && cyc < 1000) begin
            @(negedge clk);
            a_out_ready = 1'($urandom_range(0, 1));
            a_in_valid  = (sent < 60) ? 1'($urandom_range(0, 1)) : 1'b0;
            a_in_data   = 8'($urandom_range(0, 255));
            #1;
            if (prev_stall) begin
                checks++;
                if (a_out_valid !== 1'b1 || a_out_sum !== prev_sum) begin
                    errors++; $display("FAIL bp_stable: valid=%b sum=%0d want valid=1 sum=%0d", a_out_valid, a_out_sum, prev_sum);
                end
            end
            checks++;
            if (a_in_ready !== (!a_out_valid || a_out_ready)) begin
                errors++; $display("FAIL bp_in_ready: got %b want %b", a_in_ready, (!a_out_valid || a_out_ready));
            end
            if (a_out_valid && a_out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL bp_extra: out_sum=%0d with nothing expected", a_out_sum); end
                else begin
                    logic [3:0] e;
                    e = exp_q.pop_front();
                    if (a_out_sum !== e) begin errors++; $display("FAIL bp_data: beat %0d got %0d want %0d", got, a_out_sum, e); end
                end
                got++;
            end
            if (a_in_valid && a_in_ready) begin
                exp_q.push_back(4'($countones(a_in_data)));
                sent++;
            end
            prev_stall = a_out_valid && !a_out_ready;
            prev_sum   = a_out_sum;
            cyc++;
        end
        a_in_valid = 0; a_out_ready = 1;
        checks++; if (got != 60) begin errors++; $display("FAIL bp_count: got %0d outputs want 60", got); end
        @(negedge clk);
        #1;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL bp_dup: out_valid=%b after drain want 0", a_out_valid); end
    endtask

    task automatic test_wide();
        @(negedge clk);
        w_in_valid = 1; w_in_data = {9{3'd7}};
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            w_in_valid = 0;
            #1;
            checks++;
            if (i < 4) begin
                if (w_out_valid !== 1'b0) begin errors++; $display("FAIL wide_early: cycle %0d out_valid=%b want 0", i, w_out_valid); end
            end else if (w_out_valid !== 1'b1 || w_out_sum !== 7'd63) begin
                errors++; $display("FAIL wide_sum: valid=%b sum=%0d want valid=1 sum=63", w_out_valid, w_out_sum);
            end
        end
    endtask

    task automatic test_two();
        @(negedge clk);
        t_in_valid = 1; t_in_data = {2'd3, 2'd3};
        @(negedge clk);
        t_in_valid = 1; t_in_data = {2'd2, 2'd1};
        #1;
        checks++;
        if (t_out_valid !== 1'b1 || t_out_sum !== 3'd6) begin
            errors++; $display("FAIL two_sum_6: valid=%b sum=%0d want valid=1 sum=6", t_out_valid, t_out_sum);
        end
        @(negedge clk);
        t_in_valid = 0;
        #1;
        checks++;
        if (t_out_valid !== 1'b1 || t_out_sum !== 3'd3) begin
            errors++; $display("FAIL two_sum_3: valid=%b sum=%0d want valid=1 sum=3", t_out_valid, t_out_sum);
        end
    endtask

    task automatic test_flush();
        // stalled pipeline: three beats loaded, clear presented together with a fourth beat
        a_out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_in_valid = 1; a_in_data = 8'hFF;
        end
        @(negedge clk);
        a_clear = 1; a_in_valid = 1; a_in_data = 8'h0F;
        #1;
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready_stall: got %b want 0", a_in_ready); end
        @(negedge clk);
        a_clear = 0; a_in_valid = 0; a_out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_stalled: cycle %0d out_valid=%b want 0", i, a_out_valid); end
            @(negedge clk);
        end
        // flowing pipeline: clear with in_ready=1 still drops everything
        for (int i = 0; i < 2; i++) begin
            a_in_valid = 1; a_in_data = 8'h33;
            @(negedge clk);
        end
        a_clear = 1; a_in_valid = 1; a_in_data = 8'hF0;
        #1;
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready_flow: got %b want 1", a_in_ready); end
        @(negedge clk);
        a_clear = 0; a_in_valid = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_flowing: cycle %0d out_valid=%b want 0", i, a_out_valid); end
            @(negedge clk);
        end
        send_default(8'h3C, 4'd4, "flush_next");
    endtask

    task automatic test_reset_midflight();
        a_out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_in_valid = 1; a_in_data = 8'h07;
        end
        @(negedge clk);
        a_in_valid = 0;
        #1;
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre: out_valid=%b want 1", a_out_valid); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: out_valid=%b want 0", a_out_valid); end
        checks++; if (a_out_sum !== 4'd0) begin errors++; $display("FAIL midrst_sum: out_sum=%0d want 0", a_out_sum); end
        @(posedge clk);
        #3 rst_n = 1'b1;
        a_out_ready = 1;
        @(negedge clk);
        #1;
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b want 1", a_in_ready); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale: cycle %0d out_valid=%b want 0", i, a_out_valid); end
        end
        send_default(8'h81, 4'd2, "midrst_next");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_wide();
        test_two();
        test_flush();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
